// File: rtl/sr_bank_arbiter.sv
// Round-robin arbiter giving NREQ requesters serialized S/R access to a shared bank of NBITS SR bits.
// One command per IDLE->EXEC->DONE pass; illegal S=R=1 commands are flagged and counted.
//
// state | meaning
// IDLE  | waiting for any req; winner and its command latched on exit
// EXEC  | gnt held for the winner; command applied to q on exit
// DONE  | ack (and err for S=R=1) pulse
module sr_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NBITS = 8,
  localparam int IW = $clog2(NBITS),
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      cmd_s,
  input  logic [NREQ-1:0]      cmd_r,
  input  logic [NREQ*IW-1:0]   cmd_idx,
  input  logic                 clr,
  output logic [NREQ-1:0]      gnt,
  output logic                 ack,
  output logic                 err,
  output logic                 busy,
  output logic [NBITS-1:0]     q,
  output logic [7:0]           err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   win;
  logic            win_found;
  logic [PW-1:0]   lat_win;
  logic            lat_s;
  logic            lat_r;
  logic [IW-1:0]   lat_idx;
  logic [NREQ-1:0] gnt_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|req) state_nxt = EXEC;
      EXEC:    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    gnt  = gnt_r;
    ack  = (state == DONE);
    err  = (state == DONE) && lat_s && lat_r;
    busy = (state != IDLE);
  end

  // Search starts just above the last winner so every requester is served within NREQ passes.
  always_comb begin
    win       = ptr;
    win_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[(int'(ptr) + k) % NREQ]) begin
        win       = PW'((int'(ptr) + k) % NREQ);
        win_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= PW'(NREQ - 1);
      lat_win <= '0;
      lat_s   <= 1'b0;
      lat_r   <= 1'b0;
      lat_idx <= '0;
      gnt_r   <= '0;
      q       <= '0;
      err_cnt <= 8'd0;
    end else begin
      if (state == IDLE && |req) begin
        lat_win <= win;
        lat_s   <= cmd_s[win];
        lat_r   <= cmd_r[win];
        lat_idx <= cmd_idx[int'(win)*IW +: IW];
        gnt_r   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
      end
      if (state == EXEC) begin
        gnt_r <= '0;
        ptr   <= lat_win;
        if (lat_s && lat_r && err_cnt != 8'hFF) begin
          err_cnt <= err_cnt + 8'd1;
        end
      end
      // clr wins over a coincident command; S=R (00 or 11) leaves the bit alone.
      if (clr) begin
        q <= '0;
      end else if (state == EXEC && lat_s != lat_r) begin
        q[lat_idx] <= lat_s;
      end
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// Scoreboard bench for sr_bank_arbiter: a round-robin reference model predicts each ack's
// winner, q, err and err_cnt; an independent monitor compares whenever ack is presented.
module tb_sr_bank_arbiter;
  localparam int N  = 4;
  localparam int IW = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  cmd_s = '0;
  logic [3:0]  cmd_r = '0;
  logic [11:0] cmd_idx = '0;
  logic        clr = 1'b0;
  logic [3:0]  gnt;
  logic        ack;
  logic        err;
  logic        busy;
  logic [7:0]  q;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  sr_bank_arbiter #(.NREQ(4), .NBITS(8)) dut (
    .clk(clk), .rst(rst), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r),
    .cmd_idx(cmd_idx), .clr(clr), .gnt(gnt), .ack(ack), .err(err),
    .busy(busy), .q(q), .err_cnt(err_cnt)
  );

  typedef struct {
    int         win;
    logic [7:0] q;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [7:0] mq = '0;
  int         mptr = N - 1;
  int         mcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s at time %0t", name, $time);
  endtask

  logic [3:0] prev_gnt = '0;
  exp_t       mon_e;

  always @(negedge clk) begin
    if (ack) begin
      if (sb.size() == 0) begin
        fail("unexpected_ack");
      end else begin
        mon_e = sb.pop_front();
        chk("grant_winner", 32'(prev_gnt), 32'(1) << mon_e.win);
        chk("q_after_cmd", 32'(q), 32'(mon_e.q));
        chk("err_pulse", 32'(err), 32'(mon_e.err));
        chk("err_cnt", 32'(err_cnt), 32'(mon_e.cnt));
      end
    end else if (err) begin
      fail("err_without_ack");
    end
    chk("busy_state", 32'(busy), 32'((gnt != 4'd0) || ack));
    prev_gnt = gnt;
  end

  task automatic model_reset();
    sb.delete();
    mq   = '0;
    mptr = N - 1;
    mcnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    req = '0;
    clr = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_q", 32'(q), 0);
    chk("rst_err_cnt", 32'(err_cnt), 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
  endtask

  task automatic clr_idle();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mq = '0;
  endtask

  // Every requester in mask issues one command and drops req on its own ack.
  task automatic run_batch(input logic [3:0] mask, input logic [3:0] s, input logic [3:0] r,
                           input logic [11:0] idx, input bit clr_exec, input bit drop_early,
                           input bit chk_spacing);
    logic [3:0] pend;
    logic [3:0] g;
    logic [3:0] gp;
    int n, acks, cyc, w;
    bit found;
    int gt[$];
    exp_t e;
    pend = mask;
    n = 0;
    while (pend != 4'd0) begin
      found = 1'b0;
      w = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && pend[(mptr + k) % N]) begin
          found = 1'b1;
          w = (mptr + k) % N;
        end
      end
      e.win = w;
      e.err = 1'b0;
      if (s[w] && r[w]) begin
        e.err = 1'b1;
        if (mcnt < 255) mcnt++;
      end else if (s[w]) begin
        mq[idx[w*IW +: IW]] = 1'b1;
      end else if (r[w]) begin
        mq[idx[w*IW +: IW]] = 1'b0;
      end
      if (clr_exec) mq = '0;
      e.q = mq;
      e.cnt = 8'(mcnt);
      mptr = w;
      pend[w] = 1'b0;
      n++;
      sb.push_back(e);
    end
    @(negedge clk);
    req = mask;
    cmd_s = s;
    cmd_r = r;
    cmd_idx = idx;
    acks = 0;
    cyc = 0;
    g = '0;
    gp = '0;
    while (acks < n && cyc < 6*n + 6) begin
      @(negedge clk);
      cyc++;
      if (gnt != 4'd0 && gp == 4'd0) begin
        gt.push_back(cyc);
        if (gt.size() == 1) chk("first_gnt_latency", 32'(cyc), 1);
        g = gnt;
        // Command is latched already; disturbing the winner's inputs must not matter.
        for (int b = 0; b < N; b++) begin
          if (gnt[b]) begin
            cmd_s[b] = 1'($urandom);
            cmd_r[b] = 1'($urandom);
            cmd_idx[b*IW +: IW] = 3'($urandom);
          end
        end
        if (clr_exec) clr = 1'b1;
        if (drop_early) req = req & ~gnt;
      end else begin
        clr = 1'b0;
      end
      if (ack) begin
        acks++;
        req = req & ~g;
      end
      gp = gnt;
    end
    if (acks < n) fail("batch_timeout");
    req = '0;
    clr = 1'b0;
    if (chk_spacing) begin
      chk("gnt_count", 32'(gt.size()), 32'(n));
      for (int i = 1; i < gt.size(); i++) chk("gnt_spacing", 32'(gt[i] - gt[i-1]), 3);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Single set on idx 5 straight after reset
    run_batch(4'b0001, 4'b0001, 4'b0000, 12'd5, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("ack_one_cycle", 32'(ack), 0);
    chk("q_0x20", 32'(q), 32'h20);

    // All four requesting: order 0,1,2,3, three cycles apart
    do_reset();
    run_batch(4'b1111, 4'($urandom), 4'($urandom), 12'($urandom), 1'b0, 1'b0, 1'b1);

    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 99) < 15) clr_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      run_batch(4'($urandom_range(1, 15)), 4'($urandom), 4'($urandom), 12'($urandom),
                1'b0, 1'b0, 1'b0);
    end

    // Reset on idx 0 from q=0x01 with coincident clr
    clr_idle();
    run_batch(4'b0010, 4'b0010, 4'b0000, 12'd0, 1'b0, 1'b0, 1'b0);
    chk("q_pre_clr", 32'(q), 32'h01);
    run_batch(4'b0010, 4'b0000, 4'b0010, 12'd0, 1'b1, 1'b0, 1'b0);

    // Requester 0 drops req during EXEC
    run_batch(4'b0001, 4'b0001, 4'b0000, 12'd6, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    chk("idle_gnt_after_drop", 32'(gnt), 0);
    chk("idle_busy_after_drop", 32'(busy), 0);

    // Reset asserted during EXEC aborts the command
    @(negedge clk);
    req = 4'b0001;
    cmd_s = 4'b0001;
    cmd_r = 4'b0000;
    cmd_idx = 12'd4;
    @(negedge clk);
    chk("abort_gnt_before", 32'(gnt), 32'h1);
    rst = 1'b0;
    #1;
    chk("abort_gnt", 32'(gnt), 0);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    model_reset();
    repeat (4) begin
      @(negedge clk);
      chk("abort_no_ack", 32'(ack), 0);
    end
    chk("abort_q", 32'(q), 0);

    // Fill the bank, then 256 illegal commands from requester 2 on idx 3
    for (int k = 0; k < 8; k++) run_batch(4'b0100, 4'b0100, 4'b0000, 12'(k << 6), 1'b0, 1'b0, 1'b0);
    chk("q_full", 32'(q), 32'hFF);
    for (int k = 0; k < 256; k++) run_batch(4'b0100, 4'b0100, 4'b0100, 12'(3 << 6), 1'b0, 1'b0, 1'b0);
    chk("err_cnt_saturated", 32'(err_cnt), 255);
    chk("q_after_illegal", 32'(q), 32'hFF);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_bank_arbiter.md
SR_BANK_ARBITER -- requirements
Module: sr_bank_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the SR register bank.
REQ-002 Parameter NBITS, default 8: number of SR-controlled bits in the bank; index width IW = clog2(NBITS) = 3.
REQ-003 clk  input  1  single clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester level request; held until ack is seen.
REQ-006 cmd_s  input  NREQ  per-requester S command bit.
REQ-007 cmd_r  input  NREQ  per-requester R command bit.
REQ-008 cmd_idx  input  NREQ*IW  per-requester target bit index; requester i uses slice [i*IW +: IW].
REQ-009 clr  input  1  synchronous clear of the whole bank.
REQ-010 gnt  output  NREQ  one-hot grant, registered.
REQ-011 ack  output  1  one-cycle completion pulse for the granted command.
REQ-012 err  output  1  one-cycle pulse, coincident with ack, for an illegal S=R=1 command.
REQ-013 busy  output  1  high whenever the FSM is not IDLE.
REQ-014 q  output  NBITS  SR bank state.
REQ-015 err_cnt  output  8  saturating count of illegal commands.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC, DONE; transitions are IDLE->EXEC when |req, EXEC->DONE unconditionally, DONE->IDLE unconditionally.
REQ-017 In IDLE with |req, the block SHALL select the winner round-robin, searching upward from (ptr+1) mod NREQ, and at the same edge SHALL latch the winner's cmd_s, cmd_r and cmd_idx.
REQ-018 gnt SHALL be one-hot for the winner throughout EXEC and zero in every other state.
REQ-019 On the EXEC->DONE edge, the latched command SHALL be applied to q[idx]: {S,R}=00 no change, 01 clears the bit, 10 sets the bit, 11 no change.
REQ-020 Only q[idx] SHALL change on that edge.
REQ-021 On the EXEC->DONE edge, ptr SHALL be updated to the winner index.
REQ-022 ack SHALL be high for exactly the DONE cycle; err SHALL also be high in that cycle iff the latched command was 11.
REQ-023 err_cnt SHALL increment by 1 on each illegal command and SHALL saturate at 255.
REQ-024 req SHALL be ignored in EXEC and DONE; arbitration occurs only in IDLE.
REQ-025 Latency SHALL be: gnt visible one cycle after req is sampled; q updated and ack visible two cycles after req is sampled; maximum throughput is one command per 3 cycles.
REQ-026 If req drops while in EXEC, the latched command SHALL still complete and be acked.
REQ-027 clr SHALL zero q on any edge in any state and SHALL override a coincident EXEC->DONE update; that command SHALL still be acked, and err/err_cnt SHALL still reflect it.
REQ-028 The latched cmd_idx SHALL be used unmodified; NBITS is a power of two, so no out-of-range index exists.
REQ-029 busy SHALL equal (state != IDLE).

Reset
REQ-030 While rst=0, the block SHALL immediately set state=IDLE, gnt=0, ack=0, err=0, busy=0, q=0, err_cnt=0 and ptr=NREQ-1, so requester 0 has first priority.
REQ-031 Reset asserted in EXEC or DONE SHALL abort the command; no ack SHALL follow, and q SHALL remain zero after release.
REQ-032 The first arbitration SHALL occur on the first posedge with rst=1 and |req.

Verification
REQ-033 Reset release, req=0001, cmd_s/r=10, idx0=5 -> gnt=0001 next cycle; then q=0x20 and ack=1 for one cycle, err=0.
REQ-034 req=1111 held, each dropping its req on its own ack -> grant order 0,1,2,3, with each gnt exactly 3 cycles apart.
REQ-035 Requester 2 issues 11 on idx 3 with q=0xFF -> q stays 0xFF, ack=err=1 together, err_cnt 0->1; after 256 such commands err_cnt=255.
REQ-036 Requester 1 clears idx 0 (01) from q=0x01 while clr=1 on the same EXEC edge -> q=0x00, ack=1.
REQ-037 Set command granted, rst pulsed low during EXEC -> gnt=0 and busy=0 immediately, no ack, q=0x00 after release.
REQ-038 Requester 0 drops req during EXEC -> command still applied, ack=1, FSM returns to IDLE with gnt=0.
